seq_detector_1011: RTL and testbench
====================================

SEQ_DETECTOR_1011 -- requirements
Module: seq_detector_1011

Interface
REQ-001 SHALL provide parameter WIDTH, default 8: parallel word length in bits, legal values 2..32.
REQ-002 SHALL provide parameter CNT_W, default 8: width of the detection counter, legal values 1..16.
REQ-003 SHALL provide port clk, input, 1 bit: single clock; all state updates on posedge clk.
REQ-004 SHALL provide port rst, input, 1 bit: reset, synchronous and active-low; sampled only on posedge clk.
REQ-005 SHALL provide port en, input, 1 bit: sample enable; d is accepted only on edges where en=1.
REQ-006 SHALL provide port d, input, 1 bit: serial data bit, driven by the upstream D flip-flop q.
REQ-007 SHALL provide port clr, input, 1 bit: synchronous clear of det_cnt only.
REQ-008 SHALL provide port q_par, output, WIDTH bits: shifted parallel word, most recent bit in bit 0.
REQ-009 SHALL provide port word_valid, output, 1 bit: one-cycle pulse when q_par holds a complete word.
REQ-010 SHALL provide port det, output, 1 bit: registered Moore flag for the pattern 1011.
REQ-011 SHALL provide port det_cnt, output, CNT_W bits: saturating count of detections.

Function
REQ-012 SHALL implement a Moore FSM with states IDLE, S1, S10, S101 and S1011, where the suffix 1, 10, 101 or 1011 matched so far names each state.
REQ-013 SHALL use these transitions for (d=0 / d=1): IDLE->IDLE/S1; S1->S10/S1; S10->IDLE/S101; S101->S10/S1011; S1011->S10/S1.
REQ-014 SHALL detect overlapping occurrences; for example, 1011011 yields two detections.
REQ-015 SHALL drive det=1 only while the FSM is in S1011.
REQ-016 SHALL assert det in the cycle that directly follows the edge sampling the final 1, giving a latency of 1 clock.
REQ-017 SHALL increment det_cnt by 1 on every edge at which the FSM enters S1011.
REQ-018 SHALL saturate det_cnt at 2^CNT_W-1 and SHALL NOT wrap it to 0.
REQ-019 SHALL set det_cnt to 0 on an edge with clr=1; clr SHALL win over a simultaneous detection, leaving det_cnt=0.
REQ-020 SHALL still update FSM state and det on an edge with clr=1.
REQ-021 SHALL shift on each accepted bit: q_par <= {q_par[WIDTH-2:0], d}.
REQ-022 SHALL keep an internal bit counter running 0..WIDTH-1 and wrapping to 0 after the WIDTH-th accepted bit.
REQ-023 SHALL set word_valid=1 for exactly the one cycle after the edge accepting the WIDTH-th bit of a word; q_par SHALL hold that full word during that cycle.
REQ-024 SHALL make word_valid=1 and det=1 independent of each other and allow both in the same cycle.
REQ-025 SHALL hold FSM state, q_par, det, det_cnt and the bit counter on an edge with en=0.
REQ-026 SHALL force word_valid=0 on an edge with en=0.
REQ-027 SHALL still apply clr on an edge with en=0.
REQ-028 SHALL let an en=0 gap split neither a pattern nor a word: accepted bits are contiguous regardless of gaps.
REQ-029 SHALL register all outputs, with no combinational path from any input to any output.

Reset
REQ-030 SHALL, on an edge with rst=0, set FSM=IDLE, q_par=0, word_valid=0, det=0, det_cnt=0 and the bit counter to 0.
REQ-031 SHALL give rst priority over en, clr and d.
REQ-032 SHALL discard a partial word or partial pattern in progress when reset occurs mid-operation.
REQ-033 SHALL take the first accepted bit after rst returns to 1 as bit 0 of a new word.

Verification
REQ-034 SHALL cover: rst=0 for 2 edges with en=1 and d toggling -> all outputs 0.
REQ-035 SHALL cover: en=1, d=1,0,1,1 -> det=1 for exactly one cycle after the 4th edge and det_cnt=1.
REQ-036 SHALL cover: en=1, d=1,0,1,1,0,1,1 -> det pulses after the 4th and 7th edges and det_cnt=2.
REQ-037 SHALL cover: WIDTH=8, d=1,0,1,0,0,1,0,1 with en=0 for 3 cycles after the 4th bit -> q_par=8'hA5 with a single word_valid pulse, and no pulse during the gap.
REQ-038 SHALL cover: CNT_W=2, five detections -> det_cnt=3 and held; then clr=1 together with a 6th detection -> det_cnt=0 and det=1.
REQ-039 SHALL cover: rst=0 after 5 bits of a word, then 8 bits 8'hFF -> exactly one word_valid with q_par=8'hFF, and det_cnt unchanged at 0.

Source files
------------

// File: rtl/seq_detector_1011.sv
// Serial-in detector: shifts accepted bits into a parallel word, flags each
// overlapping occurrence of 1011 with a Moore FSM and counts detections.
module seq_detector_1011 #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             d,
  input  logic             clr,
  output logic [WIDTH-1:0] q_par,
  output logic             word_valid,
  output logic             det,
  output logic [CNT_W-1:0] det_cnt,
  output logic [2:0]       dbg_state_o
);

  localparam int BC_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [BC_W-1:0]  BC_LAST = BC_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] S1    = 3'd1;
  localparam logic [2:0] S10   = 3'd2;
  localparam logic [2:0] S101  = 3'd3;
  localparam logic [2:0] S1011 = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] q_par_q, q_par_d;
  logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic             wv_q, wv_d;
  logic             det_q, det_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Each state names the longest suffix of accepted bits that prefixes 1011.
  always_comb begin
    state_d = state_q;
    if (en) begin
      case (state_q)
        IDLE:    state_d = d ? S1    : IDLE;
        S1:      state_d = d ? S1    : S10;
        S10:     state_d = d ? S101  : IDLE;
        S101:    state_d = d ? S1011 : S10;
        S1011:   state_d = d ? S1    : S10;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    q_par_d   = q_par_q;
    bit_cnt_d = bit_cnt_q;
    wv_d      = 1'b0;
    if (en) begin
      q_par_d   = {q_par_q[WIDTH-2:0], d};
      bit_cnt_d = (bit_cnt_q == BC_LAST) ? '0 : bit_cnt_q + 1'b1;
      wv_d      = (bit_cnt_q == BC_LAST);
    end
  end

  // S1011 cannot loop on itself, so reaching it on an accepted bit is an entry.
  always_comb begin
    det_d = (state_d == S1011);
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (state_d == S1011) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      q_par_q   <= '0;
      bit_cnt_q <= '0;
      wv_q      <= 1'b0;
      det_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      q_par_q   <= q_par_d;
      bit_cnt_q <= bit_cnt_d;
      wv_q      <= wv_d;
      det_q     <= det_d;
      cnt_q     <= cnt_d;
    end
  end

  assign q_par       = q_par_q;
  assign word_valid  = wv_q;
  assign det         = det_q;
  assign det_cnt     = cnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seq_detector_1011.sv
// Bench for seq_detector_1011: a default instance and a CNT_W=2 instance share
// the same stimulus and are compared every cycle against a bit-history model.
module tb_seq_detector_1011;

  logic clk, rst, en, d, clr;

  logic [7:0] q_par_a, q_par_b;
  logic       wv_a, wv_b, det_a, det_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;
  logic [2:0] dbg_a, dbg_b;

  seq_detector_1011 #(.WIDTH(8), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .en(en), .d(d), .clr(clr),
    .q_par(q_par_a), .word_valid(wv_a), .det(det_a), .det_cnt(cnt_a),
    .dbg_state_o(dbg_a)
  );

  seq_detector_1011 #(.WIDTH(8), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .en(en), .d(d), .clr(clr),
    .q_par(q_par_b), .word_valid(wv_b), .det(det_b), .det_cnt(cnt_b),
    .dbg_state_o(dbg_b)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_err    = 0;
  logic chk_en = 1'b0;

  // model state: last four accepted bits, accepted-bit count since reset
  logic [3:0] m_hist;
  int         m_nacc;
  logic [7:0] m_q;
  logic       m_wv, m_det;
  int         m_cnt_a, m_cnt_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input logic r, input logic e, input logic dd, input logic c);
    if (!r) begin
      m_hist = 4'b0; m_nacc = 0; m_q = 8'h00; m_wv = 1'b0; m_det = 1'b0;
      m_cnt_a = 0; m_cnt_b = 0;
    end else begin
      m_wv = 1'b0;
      if (e) begin
        m_hist = {m_hist[2:0], dd};
        m_nacc++;
        m_q = {m_q[6:0], dd};
        m_wv = (m_nacc % 8 == 0);
        m_det = (m_nacc >= 4) && (m_hist == 4'b1011);
        if (m_det) begin
          if (m_cnt_a < 255) m_cnt_a++;
          if (m_cnt_b < 3) m_cnt_b++;
        end
      end
      if (c) begin
        m_cnt_a = 0; m_cnt_b = 0;
      end
    end
  endtask

  // driver: inputs change 1 time unit after the active edge
  task automatic step(input logic r, input logic e, input logic dd, input logic c);
    rst = r; en = e; d = dd; clr = c;
    @(posedge clk);
    model_update(r, e, dd, c);
    #1;
  endtask

  task automatic bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b1, 1'b1, v[i], 1'b0);
  endtask

  // scoreboard compare on the falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("q_par_a", 32'(q_par_a), 32'(m_q));
      check("wv_a",    32'(wv_a),    32'(m_wv));
      check("det_a",   32'(det_a),   32'(m_det));
      check("cnt_a",   32'(cnt_a),   32'(m_cnt_a));
      check("q_par_b", 32'(q_par_b), 32'(m_q));
      check("wv_b",    32'(wv_b),    32'(m_wv));
      check("det_b",   32'(det_b),   32'(m_det));
      check("cnt_b",   32'(cnt_b),   32'(m_cnt_b));
    end
  end

  int wv_pulses;

  initial begin
    rst = 1'b1; en = 1'b0; d = 1'b0; clr = 1'b0;

    // reset for two edges with en=1 and d toggling
    step(1'b0, 1'b1, 1'b1, 1'b1);
    chk_en = 1'b1;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("rst_q_par", 32'(q_par_a), 32'h0);
    check("rst_det",   32'(det_a),   32'h0);
    check("rst_wv",    32'(wv_a),    32'h0);
    check("rst_cnt",   32'(cnt_a),   32'h0);

    // 1011 then overlapping 011, then one more bit to complete a word
    bits(32'b1011, 4);
    check("p1_det", 32'(det_a), 32'h1);
    check("p1_cnt", 32'(cnt_a), 32'h1);
    bits(32'b0, 1);
    check("p1_det_drop", 32'(det_a), 32'h0);
    bits(32'b11, 2);
    check("p2_det", 32'(det_a), 32'h1);
    check("p2_cnt", 32'(cnt_a), 32'h2);
    bits(32'b0, 1);
    check("w1_wv",    32'(wv_a),    32'h1);
    check("w1_q_par", 32'(q_par_a), 32'hB6);

    // 0xA5 with a three-cycle gap after the fourth bit
    step(1'b0, 1'b1, 1'b0, 1'b0);
    bits(32'b1010, 4);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, i[0], 1'b0);
      check("gap_wv", 32'(wv_a), 32'h0);
    end
    bits(32'b0101, 4);
    check("a5_wv",    32'(wv_a),    32'h1);
    check("a5_q_par", 32'(q_par_a), 32'hA5);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check("a5_wv_off", 32'(wv_a),    32'h0);
    check("a5_hold",   32'(q_par_a), 32'hA5);

    // saturation on the 2-bit counter, then clr against a 6th detection
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      bits(32'b1011, 4);
      if (k == 3) check("sat_cnt4", 32'(cnt_b), 32'h3);
    end
    check("sat_cnt5", 32'(cnt_b), 32'h3);
    check("full_cnt5", 32'(cnt_a), 32'h5);
    bits(32'b101, 3);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("clr_cnt_b", 32'(cnt_b), 32'h0);
    check("clr_cnt_a", 32'(cnt_a), 32'h0);
    check("clr_det",   32'(det_b), 32'h1);
    // clr applies with en=0 too
    bits(32'b011, 3);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("clr_gap_cnt", 32'(cnt_a), 32'h0);
    check("clr_gap_det", 32'(det_a), 32'h1);

    // reset mid-word, then eight ones form exactly one word
    step(1'b0, 1'b1, 1'b0, 1'b0);
    bits(32'b11001, 5);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    wv_pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0);
      if (wv_a) wv_pulses++;
    end
    check("ff_q_par", 32'(q_par_a), 32'hFF);
    check("ff_pulses", 32'(wv_pulses), 32'h1);
    check("ff_cnt", 32'(cnt_a), 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
